fetch_queue: RTL and testbench

//   Instruction prefetch buffer between instruction memory and the IF/ID register.
//   - Owns the fetch PC and drives the instruction-memory address.
//   - Captures one 32-bit instruction plus its PC per cycle into a DEPTH-entry FIFO.
//   - Presents the FIFO head to the IF/ID stage with a valid/ready handshake, so a

---
 rtl/fetch_queue_if.sv | 47 ++++
 rtl/fetch_queue.sv | 83 ++++++++
 tb/tb_fetch_queue.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory port, branch redirect and IF/ID head handshake.
// master = the queue itself, slave = the environment (imem + decode).
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [63:0]      imem_addr;
  logic [31:0]      imem_instr;
  logic             redirect;
  logic [63:0]      redirect_addr;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [63:0]      out_pc;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect,
    input  redirect_addr,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output count,
    output full,
    output empty
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect,
    output redirect_addr,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  count,
    input  full,
    input  empty
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: owns the fetch PC, queues {instr, pc} pairs in a
// DEPTH-entry FIFO and hands the head to IF/ID; a redirect flushes and refetches.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [63:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      instr_mem_q [DEPTH];
  logic [63:0]      pc_mem_q    [DEPTH];

  logic             head_valid;
  logic             deq;
  logic             enq;
  logic [63:0]      redirect_pc;

  assign head_valid  = (count_q != '0);
  assign deq         = head_valid & bus.out_ready;
  // A full queue can still take a word when the head leaves in the same cycle.
  assign enq         = !bus.redirect & ((count_q < CNT_W'(DEPTH)) | deq);
  assign redirect_pc = bus.redirect_addr & ~64'h3;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (bus.redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (enq) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + 64'd4;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage has no reset; stale entries are masked by count.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem_q[wr_ptr_q] <= bus.imem_instr;
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = head_valid;
  assign bus.out_instr = instr_mem_q[rd_ptr_q];
  assign bus.out_pc    = pc_mem_q[rd_ptr_q];
  assign bus.count     = count_q;
  assign bus.full      = (count_q == CNT_W'(DEPTH));
  assign bus.empty     = !head_valid;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, stall-to-full, drain, redirect,
// async reset, redirect-with-dequeue and fetch PC wrap.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory: each word is tagged with the low half of its address.
  assign bus.imem_instr = 32'hA000_0000 ^ bus.imem_addr[31:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_instr(input logic [63:0] pc);
    return 32'hA000_0000 ^ pc[31:0];
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    rst               = 1'b1;
    bus.redirect      = 1'b0;
    bus.redirect_addr = 64'h0;
    bus.out_ready     = 1'b1;
    #12;
    rst = 1'b0;

    // Reset state
    check_eq("rst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_empty", 64'(bus.empty), 64'd1);
    check_eq("rst_full", 64'(bus.full), 64'd0);
    check_eq("rst_count", 64'(bus.count), 64'd0);
    check_eq("rst_addr", bus.imem_addr, 64'h0);

    // Streaming with decode always ready: one entry in flight
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("stream_valid", 64'(bus.out_valid), 64'd1);
      check_eq("stream_pc", bus.out_pc, 64'(4 * i));
      check_eq("stream_instr", 64'(bus.out_instr), 64'(exp_instr(64'(4 * i))));
      check_eq("stream_count", 64'(bus.count), 64'd1);
    end

    // Decode stall from reset fills the queue, head stays stable
    bus.out_ready = 1'b0;
    pulse_reset();
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_eq("stall_count", 64'(bus.count), 64'((i < 4) ? i : 4));
      check_eq("stall_head_pc", bus.out_pc, 64'h0);
    end
    check_eq("stall_full", 64'(bus.full), 64'd1);
    check_eq("stall_addr", bus.imem_addr, 64'h10);

    // Drain a full queue: in-order, enq+deq keeps count at DEPTH
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_eq("drain_pc", bus.out_pc, 64'(4 * i));
      check_eq("drain_instr", 64'(bus.out_instr), 64'(exp_instr(64'(4 * i))));
      check_eq("drain_count", 64'(bus.count), 64'd4);
    end

    // Async reset mid-cycle with the queue full
    bus.out_ready = 1'b0;
    check_eq("pre_rst_full", 64'(bus.full), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_valid", 64'(bus.out_valid), 64'd0);
    check_eq("async_addr", bus.imem_addr, 64'h0);
    check_eq("async_empty", 64'(bus.empty), 64'd1);
    rst = 1'b0;

    // Redirect with three queued entries; low address bits ignored
    for (int i = 0; i < 3; i++) tick();
    check_eq("pre_redir_count", 64'(bus.count), 64'd3);
    bus.redirect      = 1'b1;
    bus.redirect_addr = 64'h103;
    tick();
    bus.redirect = 1'b0;
    check_eq("redir_count", 64'(bus.count), 64'd0);
    check_eq("redir_valid", 64'(bus.out_valid), 64'd0);
    check_eq("redir_addr", bus.imem_addr, 64'h100);
    tick();
    check_eq("redir_tgt_valid", 64'(bus.out_valid), 64'd1);
    check_eq("redir_tgt_pc", bus.out_pc, 64'h100);
    check_eq("redir_tgt_instr", 64'(bus.out_instr), 64'(exp_instr(64'h100)));

    // Redirect coincident with full queue and dequeue
    for (int i = 0; i < 3; i++) tick();
    check_eq("pre_rd_full", 64'(bus.full), 64'd1);
    bus.out_ready     = 1'b1;
    bus.redirect      = 1'b1;
    bus.redirect_addr = 64'h200;
    check_eq("rd_deq_valid", 64'(bus.out_valid), 64'd1);
    tick();
    bus.redirect = 1'b0;
    check_eq("rd_count", 64'(bus.count), 64'd0);
    check_eq("rd_empty", 64'(bus.empty), 64'd1);
    check_eq("rd_addr", bus.imem_addr, 64'h200);
    tick();
    check_eq("rd_tgt_pc", bus.out_pc, 64'h200);
    check_eq("rd_tgt_count", 64'(bus.count), 64'd1);

    // Fetch PC wraps modulo 2^64
    bus.redirect      = 1'b1;
    bus.redirect_addr = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus.redirect = 1'b0;
    check_eq("wrap_addr0", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check_eq("wrap_addr1", bus.imem_addr, 64'h0);
    check_eq("wrap_pc0", bus.out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("wrap_instr0", 64'(bus.out_instr), 64'(exp_instr(64'hFFFF_FFFF_FFFF_FFFC)));
    tick();
    check_eq("wrap_pc1", bus.out_pc, 64'h0);
    check_eq("wrap_count", 64'(bus.count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
